// File: rtl/seq_det_ctrl.sv
// Word-level controller: serializes a word MSB-first through a programmable pattern matcher.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; the default build is non-overlapping.
module seq_det_ctrl #(
   parameter int DATA_W = 16,
   parameter int PAT_W  = 4,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PAT_W-1:0]  pattern,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              abort,
   output logic              busy,
   output logic              match_pulse,
   output logic              done,
   output logic              found,
   output logic [CNT_W-1:0]  match_count,
   output logic [CNT_W-1:0]  first_pos
);

   localparam int FILL_W = $clog2(PAT_W + 1);
   localparam int WIN_W  = (PAT_W > 1) ? PAT_W - 1 : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] data_q, data_next;
   logic [PAT_W-1:0]  pat_q, pat_next;
   logic [WIN_W-1:0]  window, window_next;
   logic [FILL_W-1:0] fill, fill_next;
   logic [CNT_W-1:0]  bit_idx, bit_idx_next;

   logic              pulse_next;
   logic              done_next;
   logic              found_next;
   logic [CNT_W-1:0]  count_next;
   logic [CNT_W-1:0]  pos_next;

   logic              scan_bit;
   logic [PAT_W-1:0]  cand;
   logic [FILL_W-1:0] fill_inc;
   logic              hit;

   // The register keeps only the PAT_W-1 most recent bits; the bit being
   // scanned completes the candidate window in the same cycle.
   assign scan_bit = data_q[DATA_W-1];

   generate
      if (PAT_W > 1) begin : g_win
         assign cand = {window, scan_bit};
      end else begin : g_win1
         assign cand = scan_bit;
      end
   endgenerate

   assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
   assign hit      = (fill_inc == FILL_FULL) && (cand == pat_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples
         // pre-edge values, independent of statement order between blocks.
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      state_next   = state;
      data_next    = data_q;
      pat_next     = pat_q;
      window_next  = window;
      fill_next    = fill;
      bit_idx_next = bit_idx;
      pulse_next   = 1'b0;
      done_next    = 1'b0;
      found_next   = found;
      count_next   = match_count;
      pos_next     = first_pos;

      case (state)
         IDLE: begin
            // in_ready is asserted throughout IDLE, so in_valid alone is an accept.
            if (in_valid) begin
               data_next    = in_data;
               pat_next     = pattern;
               window_next  = '0;
               fill_next    = '0;
               bit_idx_next = '0;
               count_next   = '0;
               found_next   = 1'b0;
               pos_next     = '0;
               state_next   = SHIFT;
            end
         end

         SHIFT: begin
            data_next    = {data_q[DATA_W-2:0], 1'b0};
            window_next  = cand[WIN_W-1:0];
            fill_next    = fill_inc;
            bit_idx_next = bit_idx + CNT_W'(1);
            if (hit) begin
               pulse_next = 1'b1;
               count_next = match_count + CNT_W'(1);
               if (!found) begin
                  found_next = 1'b1;
                  pos_next   = bit_idx;
               end
`ifdef SEQ_DET_OVERLAP_EN
               fill_next = fill_inc;
`else
               fill_next = '0;
`endif
            end
            if (bit_idx == LAST_IDX) begin
               state_next = DONE;
               done_next  = 1'b1;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort wins over everything above, including a match on this cycle.
      if (abort && (state != IDLE)) begin
         state_next   = IDLE;
         window_next  = '0;
         fill_next    = '0;
         bit_idx_next = '0;
         pulse_next   = 1'b0;
         done_next    = 1'b0;
         found_next   = 1'b0;
         count_next   = '0;
         pos_next     = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q      <= '0;
         pat_q       <= '0;
         window      <= '0;
         fill        <= '0;
         bit_idx     <= '0;
         in_ready    <= 1'b1;
         busy        <= 1'b0;
         match_pulse <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         match_count <= '0;
         first_pos   <= '0;
      end else begin
         data_q      <= data_next;
         pat_q       <= pat_next;
         window      <= window_next;
         fill        <= fill_next;
         bit_idx     <= bit_idx_next;
         in_ready    <= (state_next == IDLE);
         busy        <= (state_next != IDLE);
         match_pulse <= pulse_next;
         done        <= done_next;
         found       <= found_next;
         match_count <= count_next;
         first_pos   <= pos_next;
      end
   end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: stimulus pushes expected word results, a monitor
// pops and compares them on every done pulse. Expectations follow SEQ_DET_OVERLAP_EN.
module tb_seq_det_ctrl;

   localparam int DATA_W = 16;
   localparam int PAT_W  = 4;
   localparam int CNT_W  = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [PAT_W-1:0]  pattern = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_data = '0;
   logic              abort = 1'b0;
   logic              busy;
   logic              match_pulse;
   logic              done;
   logic              found;
   logic [CNT_W-1:0]  match_count;
   logic [CNT_W-1:0]  first_pos;

   seq_det_ctrl #(
      .DATA_W(DATA_W),
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pattern    (pattern),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .abort      (abort),
      .busy       (busy),
      .match_pulse(match_pulse),
      .done       (done),
      .found      (found),
      .match_count(match_count),
      .first_pos  (first_pos)
   );

   always #5 clk = ~clk;

   typedef struct {
      int count;
      int pos;
      int found;
      int pulses;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   // {in_ready, busy, match_pulse, done, found, match_count, first_pos}
   function automatic logic [31:0] out_vec();
      return 32'({in_ready, busy, match_pulse, done, found, match_count, first_pos});
   endfunction

   localparam logic [31:0] IDLE_CLEAR = 32'({1'b1, 14'b0});

   // ---------------- monitor ----------------
   int   cyc = 0;
   int   start_cyc = 0;
   int   pulses = 0;
   logic busy_d = 1'b0;
   exp_t e;

   always @(negedge clk) begin
      cyc++;
      if (busy && !busy_d) begin
         start_cyc = cyc;
         pulses    = 0;
      end
      if (match_pulse) pulses++;
      if (done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'(done), 32'(0));
         end else begin
            e = sb.pop_front();
            check("match_count", 32'(match_count), 32'(e.count));
            check("first_pos",   32'(first_pos),   32'(e.pos));
            check("found",       32'(found),       32'(e.found));
            check("pulse_count", 32'(pulses),      32'(e.pulses));
            check("done_latency", 32'(cyc - start_cyc), 32'(DATA_W));
         end
      end
      busy_d = busy;
   end

   // ---------------- stimulus ----------------
   // Call #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send_word(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p);
      int g = 0;
      in_data  = d;
      pattern  = p;
      in_valid = 1'b1;
      while (!in_ready && g < 4 * DATA_W) begin
         @(posedge clk); #1;
         g++;
      end
      check("ready_wait", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = ~d;
      pattern  = ~p;
   endtask

   task automatic wait_done(input string name);
      int g = 0;
      while (g < 4 * DATA_W) begin
         @(posedge clk); #1;
         g++;
         if (done) return;
      end
      check({name, "_timeout"}, 32'(done), 32'(1));
   endtask

   task automatic run_word(input string name, input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                           input int cnt, input int pos, input int fnd, input int npulse);
      sb.push_back('{cnt, pos, fnd, npulse});
      send_word(d, p);
      wait_done(name);
      @(posedge clk); #1;
      check({name, "_done_one_cycle"}, 32'(done), 32'(0));
      check({name, "_ready_after"}, 32'(in_ready), 32'(1));
   endtask

   initial begin
      int gap;
      int guard;
      int dones;
      bit seen_done;

      #2 reset = 1'b1;
      #20;
      check("reset_outputs", out_vec(), IDLE_CLEAR);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;

      // AAAA / 1010: matches at k=3,7,11,15 (non-overlap) or every odd k from 3 (overlap)
`ifdef SEQ_DET_OVERLAP_EN
      run_word("aaaa", 16'hAAAA, 4'b1010, 7, 3, 1, 7);
`else
      run_word("aaaa", 16'hAAAA, 4'b1010, 4, 3, 1, 4);
`endif
      run_word("zero", 16'h0000, 4'b1010, 0, 0, 0, 0);
`ifdef SEQ_DET_OVERLAP_EN
      run_word("ones", 16'hFF00, 4'b1111, 5, 3, 1, 5);
`else
      run_word("ones", 16'hFF00, 4'b1111, 2, 3, 1, 2);
`endif
      run_word("six", 16'h6666, 4'b0110, 4, 3, 1, 4);

      // Back-to-back with in_valid held high: 000A then A000
      sb.push_back('{1, 15, 1, 1});
      sb.push_back('{1, 3, 1, 1});
      in_data  = 16'h000A;
      pattern  = 4'b1010;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_data   = 16'hA000;
      seen_done = 1'b0;
      gap       = 0;
      guard     = 0;
      while (guard < 4 * DATA_W) begin
         @(posedge clk); #1;
         guard++;
         if (seen_done && busy) break;
         if (seen_done && in_ready) gap++;
         if (done) seen_done = 1'b1;
      end
      check("b2b_idle_gap", 32'(gap), 32'(1));
      wait_done("b2b_second");
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Abort during bit k=6
      send_word(16'hAAAA, 4'b1010);
      repeat (6) @(posedge clk);
      #1;
      check("found_before_abort", 32'(found), 32'(1));
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_outputs", out_vec(), IDLE_CLEAR);
      dones = 0;
      repeat (DATA_W + 4) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'(0));

      // Reset during SHIFT, then a clean scan
      send_word(16'hAAAA, 4'b1010);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("reset_mid_shift", out_vec(), IDLE_CLEAR);
      #3 reset = 1'b0;
      @(posedge clk); #1;
`ifdef SEQ_DET_OVERLAP_EN
      run_word("after_reset", 16'hAAAA, 4'b1010, 7, 3, 1, 7);
`else
      run_word("after_reset", 16'hAAAA, 4'b1010, 4, 3, 1, 4);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
